// File: rtl/balance_pkg.sv
// Shared widths, limits and saturation helper for the balance controller.
// Imported by the PID stage and its derivative queue.
package balance_pkg;

    localparam int ERR_W        = 10;
    localparam int INT_W        = 18;
    localparam int SPD_W        = 12;
    localparam int DSAT_W       = 7;
    localparam int TOO_FAST_LIM = 1536;

    typedef logic signed [SPD_W-1:0] spd_t;

    function automatic logic signed [31:0] sat_signed(
        input logic signed [31:0] value,
        input int                 width
    );
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/pid_dterm_q.sv
// Derivative term: history of past errors, saturated difference
// against the oldest entry, scaled by the derivative gain.
module pid_dterm_q
    import balance_pkg::*;
#(
    parameter int D_COEFF = 6,
    parameter int D_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [ERR_W-1:0] err,
    output spd_t                    dterm
);

    logic signed [ERR_W-1:0] q [D_DEPTH];
    logic signed [31:0]      diff;
    logic signed [DSAT_W-1:0] dsat;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D_DEPTH; i++) q[i] <= '0;
        end else if (en) begin
            q[0] <= err;
            for (int i = 1; i < D_DEPTH; i++) q[i] <= q[i-1];
        end
    end

    always_comb begin
        diff  = 32'(err) - 32'(q[D_DEPTH-1]);
        dsat  = DSAT_W'(sat_signed(diff, DSAT_W));
        dterm = SPD_W'(32'(dsat) * D_COEFF);
    end

endmodule

// File: rtl/ptch_pid_ctrl.sv
// Balance PID stage: pitch in, saturated left/right wheel speeds out.
// Two-stage pipeline, one sample per vld, no backpressure.
module ptch_pid_ctrl
    import balance_pkg::*;
#(
    parameter int P_COEFF  = 14,
    parameter int D_COEFF  = 6,
    parameter int D_DEPTH  = 2,
    parameter int FAST_SIM = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic               rider_off,
    input  logic               en_steer,
    input  logic signed [11:0] ld_cell_diff,
    output spd_t               lft_spd,
    output spd_t               rght_spd,
    output logic               spd_vld,
    output logic               too_fast
);

    logic signed [ERR_W-1:0] s1_err;
    logic                    s1_vld;
    logic signed [INT_W-1:0] integrator;

    spd_t               d_term;
    spd_t               i_term;
    logic signed [15:0] p_term;
    logic signed [15:0] pid;
    logic signed [15:0] steer;
    logic signed [15:0] lsum;
    logic signed [15:0] rsum;
    logic signed [INT_W-1:0] int_sum;
    logic               int_ovf;
    spd_t               lft_nxt;
    spd_t               rght_nxt;
    logic               fast_nxt;

    pid_dterm_q #(
        .D_COEFF (D_COEFF),
        .D_DEPTH (D_DEPTH)
    ) u_dterm (
        .clk   (clk),
        .rst   (rst),
        .en    (s1_vld),
        .err   (s1_err),
        .dterm (d_term)
    );

    always_comb begin
        p_term = 16'(32'(s1_err) * P_COEFF);
        i_term = (FAST_SIM != 0)
               ? SPD_W'(sat_signed(32'(integrator) >>> 1, SPD_W))
               : $signed(integrator[INT_W-1:INT_W-SPD_W]);
        pid    = p_term + 16'(i_term) + 16'(d_term);
        steer  = en_steer ? 16'(ld_cell_diff >>> 3) : 16'sd0;
        lsum   = pid + steer;
        rsum   = pid - steer;
        lft_nxt  = SPD_W'(sat_signed(32'(lsum), SPD_W));
        rght_nxt = SPD_W'(sat_signed(32'(rsum), SPD_W));
        fast_nxt = (32'(lsum) > TOO_FAST_LIM) || (32'(rsum) > TOO_FAST_LIM);
        // Same-sign operands giving an opposite-sign sum means wrap: hold instead
        int_sum = integrator + INT_W'(s1_err);
        int_ovf = (integrator[INT_W-1] == s1_err[ERR_W-1]) &&
                  (int_sum[INT_W-1] != integrator[INT_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_err     <= '0;
            s1_vld     <= 1'b0;
            integrator <= '0;
            lft_spd    <= '0;
            rght_spd   <= '0;
            spd_vld    <= 1'b0;
            too_fast   <= 1'b0;
        end else begin
            s1_vld  <= vld;
            spd_vld <= s1_vld;
            if (vld) s1_err <= ERR_W'(sat_signed(32'(ptch), ERR_W));
            if (rider_off) integrator <= '0;
            else if (s1_vld && !int_ovf) integrator <= int_sum;
            if (s1_vld) begin
                if (rider_off) begin
                    lft_spd  <= '0;
                    rght_spd <= '0;
                    too_fast <= 1'b0;
                end else begin
                    lft_spd  <= lft_nxt;
                    rght_spd <= rght_nxt;
                    too_fast <= fast_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ptch_pid_ctrl.sv
// Scoreboard bench for ptch_pid_ctrl: sample-level reference model
// feeds an expectation queue drained by an independent monitor.
module tb_ptch_pid_ctrl;

    localparam int P_COEFF  = 14;
    localparam int D_COEFF  = 6;
    localparam int D_DEPTH  = 2;
    localparam int FAST_SIM = 0;

    logic               clk = 1'b0;
    logic               rst;
    logic               vld;
    logic signed [15:0] ptch;
    logic               rider_off;
    logic               en_steer;
    logic signed [11:0] ld_cell_diff;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               spd_vld;
    logic               too_fast;

    ptch_pid_ctrl #(
        .P_COEFF  (P_COEFF),
        .D_COEFF  (D_COEFF),
        .D_DEPTH  (D_DEPTH),
        .FAST_SIM (FAST_SIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vld          (vld),
        .ptch         (ptch),
        .rider_off    (rider_off),
        .en_steer     (en_steer),
        .ld_cell_diff (ld_cell_diff),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .spd_vld      (spd_vld),
        .too_fast     (too_fast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int r;
        bit tf;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_integ;
    int   m_hist[$];
    bit   m_pv;
    int   m_perr;

    function automatic int clamp(int v, int lo, int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_integ = 0;
        m_pv    = 1'b0;
        m_perr  = 0;
        m_hist.delete();
        for (int i = 0; i < D_DEPTH; i++) m_hist.push_back(0);
    endtask

    // One clock edge of the reference, evaluated on the inputs that edge will see
    task automatic model_edge();
        exp_t e;
        int   ip, dp, pid, st, l, r, s;
        if (rst) begin
            model_clear();
            return;
        end
        if (m_pv) begin
            ip = (FAST_SIM != 0) ? clamp(m_integ >>> 1, -2048, 2047)
                                 : (m_integ >>> 6);
            dp  = clamp(m_perr - m_hist[D_DEPTH-1], -64, 63) * D_COEFF;
            pid = m_perr * P_COEFF + ip + dp;
            st  = en_steer ? (int'(ld_cell_diff) >>> 3) : 0;
            l   = pid + st;
            r   = pid - st;
            if (rider_off) begin
                e.l = 0; e.r = 0; e.tf = 1'b0;
            end else begin
                e.l  = clamp(l, -2048, 2047);
                e.r  = clamp(r, -2048, 2047);
                e.tf = (l > 1536) || (r > 1536);
            end
            sbq.push_back(e);
            m_hist.push_front(m_perr);
            void'(m_hist.pop_back());
        end
        if (rider_off) m_integ = 0;
        else if (m_pv) begin
            s = m_integ + m_perr;
            if (s <= 131071 && s >= -131072) m_integ = s;
        end
        m_pv = vld;
        if (vld) m_perr = clamp(int'(ptch), -512, 511);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; vld = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (spd_vld) begin
            n_checks++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_spd_vld: got 1 expected 0");
            end else begin
                e = sbq.pop_front();
                if (int'(lft_spd) != e.l || int'(rght_spd) != e.r ||
                    too_fast != e.tf) begin
                    n_fail++;
                    $display("FAIL speeds: got l=%0d r=%0d tf=%0b expected l=%0d r=%0d tf=%0b",
                             lft_spd, rght_spd, too_fast, e.l, e.r, e.tf);
                end
            end
        end else if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            void'(sbq.pop_front());
            $display("FAIL missing_spd_vld: got 0 expected 1");
        end
    end

    initial begin
        rst = 1'b1; vld = 1'b0; ptch = '0; rider_off = 1'b0;
        en_steer = 1'b0; ld_cell_diff = '0;
        model_clear();
        @(negedge clk);

        // reset held with vld toggling
        for (int i = 0; i < 2; i++) begin
            vld = ~vld; ptch = 16'sh0100;
            cyc();
            chk("rst_lft", int'(lft_spd), 0);
            chk("rst_rght", int'(rght_spd), 0);
            chk("rst_spd_vld", int'(spd_vld), 0);
            chk("rst_too_fast", int'(too_fast), 0);
        end
        rst = 1'b0; vld = 1'b0;

        // single positive sample saturates high
        do_reset();
        vld = 1'b1; ptch = 16'sh0100;
        cyc();
        vld = 1'b0;
        cyc(); cyc();
        chk("t2_lft", int'(lft_spd), 2047);
        chk("t2_rght", int'(rght_spd), 2047);
        chk("t2_too_fast", int'(too_fast), 1);

        // most negative pitch saturates low
        do_reset();
        vld = 1'b1; ptch = 16'sh8000;
        cyc();
        vld = 1'b0;
        cyc(); cyc();
        chk("t3_lft", int'(lft_spd), -2048);
        chk("t3_too_fast", int'(too_fast), 0);

        // integrator overflow guard
        do_reset();
        vld = 1'b1; ptch = 16'sd511;
        for (int i = 0; i < 300; i++) cyc();
        vld = 1'b0;
        cyc(); cyc();
        chk("t4_integrator", int'(dut.integrator), 130816);

        // rider_off clears integrator, then D-only output
        rider_off = 1'b1;
        cyc();
        rider_off = 1'b0; vld = 1'b1; ptch = 16'sd0;
        cyc();
        vld = 1'b0;
        cyc(); cyc();
        chk("t5_integrator", int'(dut.integrator), 0);
        chk("t5_lft_donly", int'(lft_spd), -384);
        chk("t5_rght_donly", int'(rght_spd), -384);
        // rider_off coincident with second stage
        vld = 1'b1; ptch = 16'sd100;
        cyc();
        vld = 1'b0; rider_off = 1'b1;
        cyc();
        rider_off = 1'b0;
        chk("t5_ro_lft", int'(lft_spd), 0);
        chk("t5_ro_rght", int'(rght_spd), 0);
        cyc();

        // steering
        do_reset();
        vld = 1'b1; ptch = 16'sd0; en_steer = 1'b1; ld_cell_diff = 12'sd800;
        for (int i = 0; i < 4; i++) cyc();
        chk("t6_lft", int'(lft_spd), 100);
        chk("t6_rght", int'(rght_spd), -100);
        en_steer = 1'b0;
        cyc();
        chk("t6_off_lft", int'(lft_spd), 0);
        chk("t6_off_rght", int'(rght_spd), 0);
        vld = 1'b0;
        cyc(); cyc();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom % 300) == 0;
            vld          = ($urandom % 4) != 0;
            ptch         = ($urandom % 3 == 0) ? 16'($urandom)
                                               : 16'($signed(11'($urandom)));
            rider_off    = ($urandom % 40) == 0;
            en_steer     = 1'($urandom);
            ld_cell_diff = 12'($urandom);
            cyc();
        end
        rst = 1'b0; vld = 1'b0; rider_off = 1'b0;
        cyc(); cyc(); cyc();
        chk("sb_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
